// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and framing constants for imem_loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_HDR0  = 3'd0,
    S_HDR1  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5,
    S_CHK   = 3'd6
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream, imem write port and boot status bundle for imem_loader
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        reload;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wd;
  logic        cpu_rst;
  logic        done;
  logic        err;

  // master: byte source / system side; slave: the loader
  modport master (
    output in_valid, in_data, reload,
    input  in_ready, imem_we, imem_addr, imem_wd, cpu_rst, done, err
  );

  modport slave (
    input  in_valid, in_data, reload,
    output in_ready, imem_we, imem_addr, imem_wd, cpu_rst, done, err
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - packs accepted bytes MSB-first into a 32-bit word
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full
);

  logic [1:0]  r_cnt;
  logic [31:0] r_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_en) begin
      r_word <= {r_word[23:0], i_byte};
      r_cnt  <= r_cnt + 2'd1;
    end
  end

  assign o_word      = r_word;
  assign o_word_full = i_en && (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: byte stream -> imem words, holds core in reset until loaded.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);

  localparam logic [31:0] MAX_N = MAX_WORDS;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FINAL = S_CHK;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_n;
  logic [15:0] r_word_idx;
  logic [15:0] w_n_hdr;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_pack_en;
  logic        w_word_full;
  logic        w_last_word;
  logic [31:0] w_word;

  assign w_in_ready  = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                       (r_state == S_DATA) || (r_state == S_CHK);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_pack_en   = w_accept && (r_state == S_DATA);
  assign w_n_hdr     = {r_n[15:8], bus.in_data};
  assign w_last_word = (r_word_idx == (r_n - 16'd1));

  imem_loader_byte_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .i_en        (w_pack_en),
    .i_byte      (bus.in_data),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;

  // running XOR of data bytes only; header and trailer are excluded
  always_ff @(posedge clk) begin
    if (rst) begin
      r_csum <= 8'd0;
    end else if (w_accept && (r_state == S_HDR1)) begin
      r_csum <= 8'd0;
    end else if (w_pack_en) begin
      r_csum <= r_csum ^ bus.in_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_HDR0;
      r_n        <= 16'd0;
      r_word_idx <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && (r_state == S_HDR0)) begin
        r_n <= {bus.in_data, 8'h00};
      end
      if (w_accept && (r_state == S_HDR1)) begin
        r_n        <= w_n_hdr;
        r_word_idx <= 16'd0;
      end
      if (r_state == S_WRITE) begin
        r_word_idx <= r_word_idx + 16'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR0: begin
        if (w_accept) w_state_nxt = S_HDR1;
      end
      S_HDR1: begin
        if (w_accept) begin
          if (w_n_hdr == 16'd0)                  w_state_nxt = S_FINAL;
          else if ({16'd0, w_n_hdr} > MAX_N)     w_state_nxt = S_ERROR;
          else                                   w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_word_full) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_state_nxt = w_last_word ? S_FINAL : S_DATA;
      end
      S_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (w_accept) w_state_nxt = (bus.in_data == r_csum) ? S_DONE : S_ERROR;
`else
        w_state_nxt = S_ERROR;
`endif
      end
      S_DONE, S_ERROR: begin
        if (bus.reload) w_state_nxt = S_HDR0;
      end
      default: w_state_nxt = S_HDR0;
    endcase
  end

  // address advances after the WRITE cycle, so it is stable while imem_we is high
  assign bus.in_ready  = w_in_ready;
  assign bus.imem_we   = (r_state == S_WRITE);
  assign bus.imem_addr = BASE_ADDR + {14'd0, r_word_idx, 2'b00};
  assign bus.imem_wd   = w_word;
  assign bus.cpu_rst   = (r_state != S_DONE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.err       = (r_state == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;

  imem_loader_if bus();

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  int          ready_viol = 0;
  bit          mon_ready  = 1'b0;

  always @(negedge clk) begin
    if (!rst && bus.imem_we === 1'b1) begin
      got_addr.push_back(bus.imem_addr);
      got_data.push_back(bus.imem_wd);
    end
    if (mon_ready && !rst && !bus.done && !bus.err && (bus.in_ready === bus.imem_we))
      ready_viol <= ready_viol + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget;
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    budget = 0;
    while (bus.in_ready !== 1'b1 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (budget >= 100) begin
      failures++;
      $display("FAIL send_timeout byte=%02h in_ready=%b required=1", b, bus.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int gap_max);
    foreach (s[i]) send_byte(s[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_end(input int limit);
    int k = 0;
    while (bus.done !== 1'b1 && bus.err !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic do_reload();
    bus.reload = 1'b1;
    @(negedge clk);
    bus.reload = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.cpu_rst !== 1'b1 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL reload_hdr0 ready=%b cpu_rst=%b done=%b err=%b required 1 1 0 0",
               bus.in_ready, bus.cpu_rst, bus.done, bus.err);
    end
  endtask

  task automatic load_and_check(input string name, input logic [31:0] words[$], input int gap_max);
    logic [7:0]  s[$];
    logic [7:0]  x;
    logic [31:0] w;
    int          n;
    n = words.size();
    x = 8'h00;
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    foreach (words[i]) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        s.push_back(w[31 - 8*k -: 8]);
        x = x ^ w[31 - 8*k -: 8];
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(x);
`endif
    got_addr.delete();
    got_data.delete();
    ready_viol = 0;
    mon_ready  = 1'b1;
    send_stream(s, gap_max);
    wait_end(20);
    mon_ready = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.cpu_rst !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s end_state done=%b err=%b cpu_rst=%b ready=%b required 1 0 0 0",
               name, bus.done, bus.err, bus.cpu_rst, bus.in_ready);
    end
    checks++;
    if (got_addr.size() != n) begin
      failures++;
      $display("FAIL %s write_count got=%0d required=%0d", name, got_addr.size(), n);
    end
    for (int i = 0; i < n && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== BASE + 32'(4*i) || got_data[i] !== words[i]) begin
        failures++;
        $display("FAIL %s write%0d got %08h@%08h required %08h@%08h",
                 name, i, got_data[i], got_addr[i], words[i], BASE + 32'(4*i));
      end
    end
    checks++;
    if (ready_viol != 0) begin
      failures++;
      $display("FAIL %s ready_vs_write violations=%0d required=0", name, ready_viol);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.reload   = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.cpu_rst !== 1'b1 || bus.imem_we !== 1'b0 ||
        bus.done !== 1'b0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs ready=%b cpu_rst=%b we=%b done=%b err=%b required 1 1 0 0 0",
               bus.in_ready, bus.cpu_rst, bus.imem_we, bus.done, bus.err);
    end
    checks++;
    if (bus.imem_addr !== BASE || bus.imem_wd !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus addr=%08h wd=%08h required %08h 00000000", bus.imem_addr, bus.imem_wd, BASE);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] w[$];
    w = '{32'h1234_5678, 32'h9ABC_DEF0};
    load_and_check("basic", w, 0);
  endtask

  task automatic test_zero_words();
    logic [7:0] s[$];
    int k;
    do_reload();
    got_addr.delete();
    s = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(8'h00);
`endif
    send_stream(s, 0);
    k = 0;
    while (bus.done !== 1'b1 && k < 2) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (bus.done !== 1'b1 || bus.cpu_rst !== 1'b0) begin
      failures++;
      $display("FAIL zero_done done=%b cpu_rst=%b required 1 0", bus.done, bus.cpu_rst);
    end
    checks++;
    if (got_addr.size() != 0) begin
      failures++;
      $display("FAIL zero_writes got=%0d required=0", got_addr.size());
    end
  endtask

  task automatic test_oversize();
    logic [7:0] s[$];
    do_reload();
    got_addr.delete();
    s = '{8'h01, 8'h01};
    send_stream(s, 0);
    wait_end(5);
    checks++;
    if (bus.err !== 1'b1 || bus.cpu_rst !== 1'b1 || bus.done !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL oversize_err err=%b cpu_rst=%b done=%b ready=%b required 1 1 0 0",
               bus.err, bus.cpu_rst, bus.done, bus.in_ready);
    end
    checks++;
    if (got_addr.size() != 0) begin
      failures++;
      $display("FAIL oversize_writes got=%0d required=0", got_addr.size());
    end
    do_reload();
  endtask

  task automatic test_random_gaps();
    logic [31:0] w[$];
    int n;
    do_reload();
    w = '{32'h1234_5678, 32'h9ABC_DEF0};
    load_and_check("gaps_fixed", w, 3);
    for (int it = 0; it < 6; it++) begin
      do_reload();
      w.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) w.push_back($urandom);
      load_and_check("gaps_rand", w, 3);
    end
  endtask

  task automatic test_max_words();
    logic [31:0] w[$];
    do_reload();
    for (int i = 0; i < MAXW; i++) w.push_back($urandom);
    load_and_check("max_words", w, 0);
  endtask

  task automatic test_midload_rst();
    logic [7:0]  s[$];
    logic [31:0] w[$];
    do_reload();
    got_addr.delete();
    got_data.delete();
    s = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_stream(s, 0);
    checks++;
    if (got_addr.size() != 1 || got_data[0] !== 32'h1122_3344 || got_addr[0] !== BASE) begin
      failures++;
      $display("FAIL midload_partial count=%0d required=1 first=%08h required=11223344",
               got_addr.size(), (got_data.size() > 0) ? got_data[0] : 32'hx);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.cpu_rst !== 1'b1 || bus.imem_we !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL midload_rst ready=%b cpu_rst=%b we=%b done=%b required 1 1 0 0",
               bus.in_ready, bus.cpu_rst, bus.imem_we, bus.done);
    end
    w = '{32'hAABB_CCDD};
    load_and_check("after_rst", w, 0);
  endtask

  task automatic test_bad_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] s[$];
    do_reload();
    s = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
    send_stream(s, 0);
    wait_end(10);
    checks++;
    if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.cpu_rst !== 1'b1) begin
      failures++;
      $display("FAIL bad_checksum err=%b done=%b cpu_rst=%b required 1 0 1", bus.err, bus.done, bus.cpu_rst);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_words();
    test_oversize();
    test_random_gaps();
    test_max_words();
    test_midload_rst();
    test_bad_checksum();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
